// File: rtl/adc_frame_tx.sv
// Frames each 12-bit ADC sample as header, sequence, MSB, LSB, XOR checksum for the UART.
// States: IDLE wait for sample | START pulse st_o | WAIT wait for eot | NEXT load next byte | DONE pulse eof, bump seq
module adc_frame_tx #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        eoc_i,
  input  logic [11:0] din_i,
  input  logic        eot_i,
  output logic        st_o,
  output logic [7:0]  d_o,
  output logic        busy_o,
  output logic        eof_o,
  output logic        ovr_o,
  output logic [7:0]  seq_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [11:0] r_sample;
  logic [2:0]  r_idx;
  logic [7:0]  r_d;
  logic [7:0]  r_seq;
  logic        r_ovr;
  logic [7:0]  w_b2;
  logic [7:0]  w_b3;
  logic [7:0]  w_byte;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (eoc_i) w_state_nxt = S_START;
      S_START: w_state_nxt = S_WAIT;
      S_WAIT:  if (eot_i) w_state_nxt = (r_idx == 3'd4) ? S_DONE : S_NEXT;
      S_NEXT:  w_state_nxt = S_START;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // seq_o is stable for the whole frame, so it doubles as the captured sequence number
  assign w_b2 = {4'b0000, r_sample[11:8]};
  assign w_b3 = r_sample[7:0];

  always_comb begin
    w_byte = HEADER ^ r_seq ^ w_b2 ^ w_b3;
    case (r_idx)
      3'd0:    w_byte = HEADER;
      3'd1:    w_byte = r_seq;
      3'd2:    w_byte = w_b2;
      3'd3:    w_byte = w_b3;
      default: w_byte = HEADER ^ r_seq ^ w_b2 ^ w_b3;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sample <= 12'd0;
      r_idx    <= 3'd0;
      r_d      <= 8'd0;
      r_seq    <= 8'd0;
      r_ovr    <= 1'b0;
    end else begin
      if (eoc_i && (r_state != S_IDLE)) r_ovr <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (eoc_i) begin
            r_sample <= din_i;
            r_idx    <= 3'd0;
            r_d      <= HEADER;
          end
        end
        S_WAIT: begin
          if (eot_i && (r_idx != 3'd4)) r_idx <= r_idx + 3'd1;
        end
        S_NEXT: r_d   <= w_byte;
        S_DONE: r_seq <= r_seq + 8'd1;
        default: ;
      endcase
    end
  end

  assign st_o   = (r_state == S_START);
  assign d_o    = r_d;
  assign busy_o = (r_state != S_IDLE);
  assign eof_o  = (r_state == S_DONE);
  assign ovr_o  = r_ovr;
  assign seq_o  = r_seq;

endmodule

// File: tb/tb_adc_frame_tx.sv
// Bench for adc_frame_tx: table of sample frames plus hand sequences for overrun, reset and wrap.
module tb_adc_frame_tx;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        eoc_i;
  logic [11:0] din_i;
  logic        eot_i;
  logic        st_o;
  logic [7:0]  d_o;
  logic        busy_o;
  logic        eof_o;
  logic        ovr_o;
  logic [7:0]  seq_o;

  int total = 0;
  int bad   = 0;
  int uart_dly = 20;
  int gen = 0;
  logic [7:0] got [5];
  int got_n;
  int eof_n;

  typedef struct {
    logic [11:0] din;
    int          mode;
    logic [7:0]  seq;
    logic [39:0] exp;
    logic        ovr;
  } vec_t;

  vec_t tbl [5];

  always #5 clk_i = ~clk_i;

  adc_frame_tx dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .eoc_i  (eoc_i),
    .din_i  (din_i),
    .eot_i  (eot_i),
    .st_o   (st_o),
    .d_o    (d_o),
    .busy_o (busy_o),
    .eof_o  (eof_o),
    .ovr_o  (ovr_o),
    .seq_o  (seq_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] csum(input logic [7:0] s, input logic [11:0] d);
    return 8'hA5 ^ s ^ {4'h0, d[11:8]} ^ d[7:0];
  endfunction

  // UART model: end-of-byte pulse uart_dly cycles after each start; a reset cancels it
  initial begin : uart
    int g;
    eot_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (st_o) begin
        g = gen;
        repeat (uart_dly) @(posedge clk_i);
        if (g == gen) begin
          #1 eot_i = 1'b1;
          @(posedge clk_i);
          #1 eot_i = 1'b0;
        end
      end
    end
  end

  // mode: 0 plain, 1 change din after latch, 2 extra eoc during byte 2, 3 reset during byte 3 wait
  task automatic run_frame(input logic [11:0] din, input int mode, input logic [7:0] seq_exp,
                           input string tag);
    int cyc;
    bit injected;
    got_n = 0;
    eof_n = 0;
    injected = 0;
    @(posedge clk_i);
    #1;
    chk({tag, " seq before"}, seq_o, seq_exp);
    chk({tag, " idle busy"}, busy_o, 0);
    din_i = din;
    eoc_i = 1'b1;
    @(posedge clk_i);
    #1 eoc_i = 1'b0;
    @(negedge clk_i);
    chk({tag, " st latency"}, st_o, 1);
    chk({tag, " busy"}, busy_o, 1);
    cyc = 0;
    while (cyc < 2000) begin
      if (st_o) begin
        if (got_n < 5) got[got_n] = d_o;
        got_n++;
      end
      if (eot_i && got_n > 0 && got_n <= 5) chk({tag, " d_o hold"}, d_o, got[got_n-1]);
      if (eof_o) begin
        eof_n++;
        break;
      end
      if (mode == 1 && got_n == 1 && !injected) begin
        din_i = 12'h000;
        injected = 1;
      end
      if (mode == 2 && got_n == 3 && !injected) begin
        eoc_i = 1'b1;
        injected = 1;
      end else begin
        eoc_i = 1'b0;
      end
      if (mode == 3 && got_n == 4 && !st_o) begin
        gen++;
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk({tag, " rst st"}, st_o, 0);
        chk({tag, " rst d"}, d_o, 0);
        chk({tag, " rst busy"}, busy_o, 0);
        chk({tag, " rst eof"}, eof_o, 0);
        chk({tag, " rst ovr"}, ovr_o, 0);
        chk({tag, " rst seq"}, seq_o, 0);
        break;
      end
      @(negedge clk_i);
      cyc++;
    end
    chk({tag, " completed in time"}, cyc < 2000, 1);
  endtask

  task automatic chk_frame(input string tag, input logic [39:0] exp);
    chk({tag, " nbytes"}, got_n, 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("%s b%0d", tag, i), got[i], exp[39-8*i -: 8]);
    chk({tag, " eof"}, eof_n, 1);
  endtask

  task automatic quiet(input int n, input string tag);
    int act;
    act = 0;
    repeat (n) begin
      @(negedge clk_i);
      if (st_o || eof_o) act++;
    end
    chk({tag, " no activity"}, act, 0);
  endtask

  initial begin
    tbl[0] = '{12'hABC, 0, 8'h00, 40'hA5_00_0A_BC_13, 1'b0};
    tbl[1] = '{12'h123, 0, 8'h01, 40'hA5_01_01_23_86, 1'b0};
    tbl[2] = '{12'hFFF, 1, 8'h02, 40'hA5_02_0F_FF_57, 1'b0};
    tbl[3] = '{12'h000, 0, 8'h03, 40'hA5_03_00_00_A6, 1'b0};
    tbl[4] = '{12'h5A5, 2, 8'h04, 40'hA5_04_05_A5_01, 1'b1};

    rst_i = 1'b1;
    eoc_i = 1'b0;
    din_i = 12'h000;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset st", st_o, 0);
    chk("reset d", d_o, 0);
    chk("reset busy", busy_o, 0);
    chk("reset eof", eof_o, 0);
    chk("reset ovr", ovr_o, 0);
    chk("reset seq", seq_o, 0);

    for (int v = 0; v < 5; v++) begin
      run_frame(tbl[v].din, tbl[v].mode, tbl[v].seq, $sformatf("vec%0d", v));
      chk_frame($sformatf("vec%0d", v), tbl[v].exp);
      chk($sformatf("vec%0d ovr", v), ovr_o, tbl[v].ovr);
    end

    quiet(100, "after overrun");
    chk("seq after table", seq_o, 5);
    chk("busy after table", busy_o, 0);
    chk("ovr sticky", ovr_o, 1);

    run_frame(12'h777, 3, 8'h05, "midrst");
    quiet(60, "after midrst");
    chk("midrst seq", seq_o, 0);

    run_frame(12'h321, 0, 8'h00, "fresh");
    chk_frame("fresh", 40'hA5_00_03_21_87);
    chk("fresh ovr", ovr_o, 0);

    uart_dly = 2;
    for (int i = 1; i < 256; i++) begin
      logic [7:0] s;
      logic [11:0] d;
      s = i[7:0];
      d = 12'(i * 7);
      run_frame(d, 0, s, $sformatf("wrap%0d", i));
      chk($sformatf("wrap%0d b1", i), got[1], s);
      chk($sformatf("wrap%0d b4", i), got[4], csum(s, d));
    end
    run_frame(12'h456, 0, 8'h00, "f257");
    chk_frame("f257", 40'hA5_00_04_56_F7);
    @(posedge clk_i);
    #1;
    chk("seq after f257", seq_o, 1);
    chk("idle after f257", busy_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
